demux_param_stream: RTL

- Parametric 1-to-N stream distributor. It is the counterpart of the N-to-1 bus mux.
- Takes one valid/ready input stream carrying a destination select and routes each word into one of N registered output channels.
- Each channel has its own one-entry holding register and its own valid/ready handshake.
- Used wherever a single producer (e.g. a write-back or a load-response path) must feed several independent consumers under backpressure.

---
 rtl/demux_param_stream.sv | 70 +++++++
 1 files changed

// File: rtl/demux_param_stream.sv
// Parametric 1-to-N valid/ready stream distributor with a one-entry register per output channel.
// Define DEMUX_DROP_CNT_EN to add an 8-bit saturating count of words discarded for an out-of-range select.
module demux_param_stream #(
  parameter int N     = 2,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [$clog2(N)-1:0]   in_sel,
  output logic [N-1:0]           out_valid,
  input  logic [N-1:0]           out_ready,
  output logic [N*WIDTH-1:0]     out_data
`ifdef DEMUX_DROP_CNT_EN
  ,
  output logic [7:0]             drop_cnt
`endif
);

  localparam int SEL_W = $clog2(N);

  logic [N-1:0] sel_hit;
  logic         sel_oor;
  logic         in_fire;

  // One-hot decode of the select; an all-zero result means the select is out of range.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    sel_hit = '0;
    for (int k = 0; k < N; k++) begin
      sel_hit[k] = (in_sel == SEL_W'(k));
    end
  end

  assign sel_oor  = ~|sel_hit;
  assign in_ready = sel_oor | (|(sel_hit & (~out_valid | out_ready)));
  assign in_fire  = in_valid & in_ready;

  // A load wins over a drain, which is what gives back-to-back throughput on one channel.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      // NOTE: the data registers are reset too, so idle channels present a defined zero.
      out_valid <= '0;
      out_data  <= '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (in_fire && sel_hit[k]) begin
          out_valid[k]                <= 1'b1;
          out_data[k*WIDTH +: WIDTH]  <= in_data;
        end else if (out_ready[k]) begin
          out_valid[k] <= 1'b0;
        end
      end
    end
  end

`ifdef DEMUX_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (in_fire && sel_oor && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end
`endif

endmodule
